cla_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder.
- Successor to the fixed 4-bit group-generate logic: WIDTH-bit operand split into GROUP-bit lookahead groups, groups distributed across STAGES pipeline stages.
- Group carry chained stage-to-stage through registers, with a valid/ready handshake on both sides.
- Sits between operand sources and downstream datapath consumers in the adder library.

---
 rtl/cla_pipe_adder.sv | 176 +++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: parametrised pipelined carry-lookahead adder.
// WIDTH-bit operands are split into STAGES slices. Each slice is a set of
// GROUP-bit lookahead groups. The slice carry passes from stage to stage
// through registers, with valid/ready handshakes on the input and output.
// Optional feature: define CLA_PIPE_OVF_EN to add the registered
// two's-complement overflow output ovf.
module cla_pipe_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned GROUP  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned S    = WIDTH / STAGES;
  localparam int unsigned NG   = S / GROUP;
  localparam int unsigned LAST = STAGES - 1;

  // Expanded lookahead carry into position n: OR of every generate term
  // ANDed with all propagates above it, plus the carry-in ANDed with all
  // propagates below n. The carry does not ripple from bit to bit.
  function automatic logic la_carry(input logic [S-1:0] g, input logic [S-1:0] p,
                                    input logic c, input int unsigned n);
    logic r;
    logic t;
    r = 1'b0;
    for (int unsigned m = 0; m < S; m++) begin
      if (m < n) begin
        t = g[m];
        for (int unsigned k = 0; k < S; k++) begin
          if (k > m && k < n) t = t & p[k];
        end
        r = r | t;
      end
    end
    t = c;
    for (int unsigned k = 0; k < S; k++) begin
      if (k < n) t = t & p[k];
    end
    return r | t;
  endfunction

  // One slice: per-group G/P, group carries by lookahead over the groups,
  // then bit carries by lookahead inside each group. Returns {carry_out, sum}.
  function automatic logic [S:0] slice_add(input logic [S-1:0] x, input logic [S-1:0] y,
                                           input logic c);
    logic [S-1:0]  g;
    logic [S-1:0]  p;
    logic [S-1:0]  s;
    logic [S-1:0]  gj;
    logic [S-1:0]  pj;
    logic [NG-1:0] gg;
    logic [NG-1:0] pg;
    logic [NG-1:0] gc;
    g = x & y;
    p = x ^ y;
    s = '0;
    for (int unsigned j = 0; j < NG; j++) begin
      gj    = S'(g[j*GROUP +: GROUP]);
      pj    = S'(p[j*GROUP +: GROUP]);
      gg[j] = la_carry(gj, pj, 1'b0, GROUP);
      pg[j] = &p[j*GROUP +: GROUP];
    end
    for (int unsigned j = 0; j < NG; j++) begin
      gc[j] = la_carry(S'(gg), S'(pg), c, j);
    end
    for (int unsigned j = 0; j < NG; j++) begin
      gj = S'(g[j*GROUP +: GROUP]);
      pj = S'(p[j*GROUP +: GROUP]);
      for (int unsigned i = 0; i < GROUP; i++) begin
        s[j*GROUP + i] = p[j*GROUP + i] ^ la_carry(gj, pj, gc[j], i);
      end
    end
    return {la_carry(S'(gg), S'(pg), c, NG), s};
  endfunction

  logic [STAGES-1:0]            vld_q, vld_d, cry_q, cry_d, src_v, src_c;
  logic [STAGES-1:0][WIDTH-1:0] sm_q, sm_d, pa_q, pa_d, pb_q, pb_d;
  logic [STAGES-1:0][WIDTH-1:0] src_a, src_b, src_s;
  logic [STAGES-1:0][S:0]       res;
  logic                         en;
  logic                         unused_pending;

  // The whole pipe advances together whenever the output slot is free or draining.
  assign en        = out_ready | ~vld_q[LAST];
  assign in_ready  = en;
  assign out_valid = vld_q[LAST];
  assign sum       = sm_q[LAST];
  assign cout      = cry_q[LAST];

  // The already-added low operand bits stay in the stage registers but are never read again.
  assign unused_pending = ^{pa_q, pb_q};

  // Per-stage sources and slice addition. Each result goes into the next register.
  always_comb begin
    src_v = '0;
    src_c = '0;
    src_a = '0;
    src_b = '0;
    src_s = '0;
    res   = '0;
    vld_d = '0;
    cry_d = '0;
    sm_d  = '0;
    pa_d  = '0;
    pb_d  = '0;
    src_v[0] = in_valid & en;
    src_c[0] = cin;
    src_a[0] = a;
    src_b[0] = b;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_v[k] = vld_q[k-1];
      src_c[k] = cry_q[k-1];
      src_a[k] = pa_q[k-1];
      src_b[k] = pb_q[k-1];
      src_s[k] = sm_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      res[k]             = slice_add(src_a[k][k*S +: S], src_b[k][k*S +: S], src_c[k]);
      sm_d[k]            = src_s[k];
      sm_d[k][k*S +: S]  = res[k][S-1:0];
      cry_d[k]           = res[k][S];
      vld_d[k]           = src_v[k];
      pa_d[k]            = src_a[k];
      pb_d[k]            = src_b[k];
    end
  end

  // Stage registers: cleared on reset, shift only when the pipe advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cry_q <= '0;
      sm_q  <= '0;
      pa_q  <= '0;
      pb_q  <= '0;
    end else if (en) begin
      vld_q <= vld_d;
      cry_q <= cry_d;
      sm_q  <= sm_d;
      pa_q  <= pa_d;
      pb_q  <= pb_d;
    end
  end

`ifdef CLA_PIPE_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Overflow is the carry into the MSB XOR the carry out. The carry into the
  // MSB is recovered from the MSB sum bit and the MSB operand bits.
  assign ovf_d = res[LAST][S] ^ (res[LAST][S-1] ^ src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1]);
  assign ovf   = ovf_q;

  // Overflow register, kept in step with the last stage.
  always_ff @(posedge clk) begin
    if (rst)     ovf_q <= 1'b0;
    else if (en) ovf_q <= ovf_d;
  end
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed testbench for cla_pipe_adder (WIDTH=16, GROUP=4, STAGES=2).
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef CLA_PIPE_OVF_EN
  logic        ovf;
`endif

  int passed = 0;
  int total  = 0;
  int failed = 0;

  cla_pipe_adder #(.WIDTH(16), .GROUP(4), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef CLA_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks a valid output slot: out_valid, sum, cout and (if built in) ovf.
  task automatic chk_out(input string tag, input logic [15:0] es, input logic ec, input logic eo);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".sum"}, 32'(sum), 32'(es));
    chk({tag, ".cout"}, 32'(cout), 32'(ec));
`ifdef CLA_PIPE_OVF_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unexpected x");
`endif
  endtask

  task automatic drive(input logic v, input logic [15:0] xa, input logic [15:0] xb, input logic xc);
    in_valid = v;
    a        = xa;
    b        = xb;
    cin      = xc;
  endtask

  // A single transaction: accept, wait the two-cycle latency, check, then drain.
  task automatic send_one(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                          input logic xc, input logic [15:0] es, input logic ec, input logic eo);
    drive(1'b1, xa, xb, xc);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    chk({tag, ".early"}, 32'(out_valid), 32'd0);
    tick();
    chk_out(tag, es, ec, eo);
    tick();
    chk({tag, ".drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.sum", 32'(sum), 32'd0);
    chk("rst.cout", 32'(cout), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    // Carry across the full width and across the slice boundary
    send_one("full_carry", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_one("slice_cin", 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);
    send_one("mixed", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    send_one("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // Back-to-back stream at full throughput
    drive(1'b1, 16'h0001, 16'h0001, 1'b0);
    tick();
    drive(1'b1, 16'h0002, 16'h0002, 1'b0);
    tick();
    chk_out("stream0", 16'h0002, 1'b0, 1'b0);
    drive(1'b1, 16'h8000, 16'h8000, 1'b0);
    tick();
    chk_out("stream1", 16'h0004, 1'b0, 1'b0);
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0);
    tick();
    chk_out("stream2", 16'h0000, 1'b1, 1'b1);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    chk_out("stream3", 16'h8000, 1'b0, 1'b1);
    tick();
    chk("stream.empty", 32'(out_valid), 32'd0);

    // Stall: fill the pipe, then hold out_ready low for three cycles
    drive(1'b1, 16'h0005, 16'h0006, 1'b0);
    tick();
    drive(1'b1, 16'h0100, 16'h0200, 1'b0);
    tick();
    chk_out("stall.first", 16'h000B, 1'b0, 1'b0);
    out_ready = 1'b0;
    drive(1'b1, 16'hF000, 16'h1000, 1'b0);
    #1;
    chk("stall.in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("stall.hold", 16'h000B, 1'b0, 1'b0);
      chk("stall.in_ready_hold", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("stall.release_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    chk_out("stall.second", 16'h0300, 1'b0, 1'b0);
    tick();
    chk_out("stall.third", 16'h0000, 1'b1, 1'b0);
    tick();
    chk("stall.empty", 32'(out_valid), 32'd0);

    // Reset with two results in flight
    drive(1'b1, 16'h1111, 16'h1111, 1'b0);
    tick();
    drive(1'b1, 16'h2222, 16'h2222, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.valid", 32'(out_valid), 32'd0);
    chk("midrst.sum", 32'(sum), 32'd0);
    chk("midrst.cout", 32'(cout), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst.no_stale", 32'(out_valid), 32'd0);
    end
    send_one("after_rst", 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0);

    // Bubble between two valid inputs
    drive(1'b1, 16'h0F0F, 16'h00F1, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    chk_out("bubble0", 16'h1000, 1'b0, 1'b0);
    drive(1'b1, 16'h7FFF, 16'h7FFF, 1'b1);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    chk("bubble.gap", 32'(out_valid), 32'd0);
    tick();
    chk_out("bubble2", 16'hFFFF, 1'b0, 1'b1);
    tick();
    chk("bubble.empty", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
